// File: rtl/ld_gf8_pkg.sv
// GF(2^3) arithmetic, LD point type and search FSM states shared by the discrete-log search engine.
package ld_gf8_pkg;

   localparam int N = 3;
   localparam logic [N-1:0] GF_POLY = 3'b011;   // x^3 = x + 1

   // Curve y^2 + xy = x^3 + a*x^2 + b used by the point generator.
   localparam logic [N-1:0] CURVE_A = 3'b001;
   localparam logic [N-1:0] CURVE_B = 3'b010;

   typedef struct packed {
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] z;
   } ld_point_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_STEP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-2:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) p = p ^ ({{(N-1){1'b0}}, a} << i);
      end
      // Fold high terms back with x^N + GF_POLY, top bit first.
      for (int i = 2*N-2; i >= N; i--) begin
         if (p[i]) p = p ^ ({{(N-2){1'b0}}, 1'b1, GF_POLY} << (i - N));
      end
      return p[N-1:0];
   endfunction

   function automatic logic [N-1:0] gf_sq(input logic [N-1:0] a);
      return gf_mul(a, a);
   endfunction

endpackage

// File: rtl/PointDouble.sv
// Lopez-Dahab point doubling; a point with X = 0 doubles to Z = 0 (infinity).
module PointDouble
   import ld_gf8_pkg::*;
(
   input  ld_point_t i_p,
   output ld_point_t o_r
);

   logic [N-1:0] w_x2, w_z2, w_bz4, w_z3, w_x3, w_y3;

   assign w_x2  = gf_sq(i_p.x);
   assign w_z2  = gf_sq(i_p.z);
   assign w_bz4 = gf_mul(CURVE_B, gf_sq(w_z2));
   assign w_z3  = gf_mul(w_x2, w_z2);
   assign w_x3  = gf_sq(w_x2) ^ w_bz4;
   assign w_y3  = gf_mul(w_bz4, w_z3) ^
                  gf_mul(w_x3, gf_mul(CURVE_A, w_z3) ^ gf_sq(i_p.y) ^ w_bz4);

   assign o_r = '{x: w_x3, y: w_y3, z: w_z3};

endmodule

// File: rtl/ld_point_eq.sv
// Projective equality of two LD points with non-zero Z: cross-multiplied X and Y comparisons.
module ld_point_eq
   import ld_gf8_pkg::*;
(
   input  ld_point_t i_a,
   input  ld_point_t i_b,
   output logic      eq
);

   logic [N-1:0] w_za2, w_zb2;

   assign w_za2 = gf_sq(i_a.z);
   assign w_zb2 = gf_sq(i_b.z);

   assign eq = (gf_mul(i_a.x, i_b.z) == gf_mul(i_b.x, i_a.z)) &&
               (gf_mul(i_a.y, w_zb2) == gf_mul(i_b.y, w_za2));

endmodule

// File: rtl/pointAddition.sv
// General LD addition of two distinct finite points; A = -B yields Z = 0 (infinity).
module pointAddition
   import ld_gf8_pkg::*;
(
   input  ld_point_t i_a,
   input  ld_point_t i_b,
   output ld_point_t o_r
);

   logic [N-1:0] w_z1s, w_z2s, w_u, w_v, w_v2, w_w, w_uw, w_z3, w_x3, w_y3;

   assign w_z1s = gf_sq(i_a.z);
   assign w_z2s = gf_sq(i_b.z);
   // U and V are the chord numerator/denominator scaled to clear all Z denominators.
   assign w_u   = gf_mul(i_a.y, w_z2s) ^ gf_mul(i_b.y, w_z1s);
   assign w_v   = gf_mul(i_a.x, i_b.z) ^ gf_mul(i_b.x, i_a.z);
   assign w_v2  = gf_sq(w_v);
   assign w_w   = gf_mul(w_v, gf_mul(i_a.z, i_b.z));
   assign w_uw  = gf_mul(w_u, w_w);
   assign w_z3  = gf_sq(w_w);
   assign w_x3  = gf_sq(w_u) ^ w_uw ^ gf_mul(w_v2, w_w) ^ gf_mul(CURVE_A, w_z3);
   assign w_y3  = gf_mul(w_uw, gf_mul(gf_mul(i_a.x, i_a.z), gf_mul(w_z2s, w_v2)) ^ w_x3) ^
                  gf_mul(w_x3, w_z3) ^
                  gf_mul(i_a.y, gf_mul(gf_sq(w_v2), gf_mul(w_z1s, gf_sq(w_z2s))));

   assign o_r = '{x: w_x3, y: w_y3, z: w_z3};

endmodule

// File: rtl/ld_point_log_search.sv
// Discrete-log search: walks P, 2P, 3P, ... (one multiple per two clocks) until kP = Q,
// the order of P is reached, or K_MAX multiples have been tried.
module ld_point_log_search
   import ld_gf8_pkg::*;
#(
   parameter int K_MAX = 14,
   parameter int KW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [N-1:0]  px,
   input  logic [N-1:0]  py,
   input  logic [N-1:0]  pz,
   input  logic [N-1:0]  qx,
   input  logic [N-1:0]  qy,
   input  logic [N-1:0]  qz,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [KW-1:0] k
);

   localparam logic [KW-1:0] K_LAST = KW'(K_MAX);
   localparam logic [KW-1:0] K_ONE  = KW'(1);

   state_t    r_state;
   ld_point_t r_p, r_q, r_r;
   ld_point_t w_dbl, w_add;
   logic      w_eq;

   PointDouble   u_dbl (.i_p(r_p), .o_r(w_dbl));
   pointAddition u_add (.i_a(r_r), .i_b(r_p), .o_r(w_add));
   ld_point_eq   u_eq  (.i_a(r_r), .i_b(r_q), .eq(w_eq));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_q     <= '0;
         r_r     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         found   <= 1'b0;
         k       <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_p   <= '{x: px, y: py, z: pz};
                  r_q   <= '{x: qx, y: qy, z: qz};
                  found <= 1'b0;
                  // Either operand at infinity resolves on the start edge itself.
                  if (qz == '0 || pz == '0) begin
                     found   <= (qz == '0);
                     k       <= '0;
                     done    <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_r     <= '{x: px, y: py, z: pz};
                     k       <= K_ONE;
                     busy    <= 1'b1;
                     r_state <= S_CMP;
                  end
               end
            end
            S_CMP: begin
               if (r_r.z == '0 || w_eq || k == K_LAST) begin
                  found   <= (r_r.z != '0) && w_eq;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               // R = P on the first step, which the adder cannot handle.
               r_r     <= (k == K_ONE) ? w_dbl : w_add;
               k       <= k + K_ONE;
               r_state <= S_CMP;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ld_point_log_search.sv
// Bench for ld_point_log_search against an affine-coordinate elliptic-curve model.
module tb_ld_point_log_search;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [2:0] px = '0, py = '0, pz = '0, qx = '0, qy = '0, qz = '0;
   logic       busy_a, done_a, found_a, busy_b, done_b, found_b;
   logic [3:0] k_a, k_b;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   ld_point_log_search #(.K_MAX(14), .KW(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .px(px), .py(py), .pz(pz), .qx(qx), .qy(qy), .qz(qz),
      .busy(busy_a), .done(done_a), .found(found_a), .k(k_a));

   ld_point_log_search #(.K_MAX(3), .KW(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .px(px), .py(py), .pz(pz), .qx(qx), .qy(qy), .qz(qz),
      .busy(busy_b), .done(done_b), .found(found_b), .k(k_b));

   typedef struct {
      bit         inf;
      logic [2:0] x;
      logic [2:0] y;
   } aff_t;

   localparam logic [2:0] CA = 3'b001;
   localparam logic [2:0] CB = 3'b010;

   logic [2:0] cpx[$];
   logic [2:0] cpy[$];
   aff_t       gp;

   // ---------------- reference model ----------------
   function automatic logic [2:0] m_mul(input logic [2:0] a, input logic [2:0] b);
      logic [2:0] r, t;
      r = '0;
      t = a;
      for (int i = 0; i < 3; i++) begin
         if (b[i]) r = r ^ t;
         t = {t[1:0], 1'b0} ^ (t[2] ? 3'b011 : 3'b000);
      end
      return r;
   endfunction

   function automatic logic [2:0] m_inv(input logic [2:0] a);
      logic [2:0] r;
      r = '0;
      for (int i = 1; i < 8; i++) if (m_mul(a, 3'(i)) == 3'b001) r = 3'(i);
      return r;
   endfunction

   function automatic aff_t aff_add(input aff_t p, input aff_t q);
      aff_t       r;
      logic [2:0] lam;
      r.inf = 1'b0; r.x = '0; r.y = '0;
      if (p.inf) return q;
      if (q.inf) return p;
      if (p.x == q.x) begin
         if (q.y == (p.x ^ p.y)) begin
            r.inf = 1'b1;
            return r;
         end
         lam = p.x ^ m_mul(p.y, m_inv(p.x));
         r.x = m_mul(lam, lam) ^ lam ^ CA;
         r.y = m_mul(p.x, p.x) ^ m_mul(lam ^ 3'b001, r.x);
      end else begin
         lam = m_mul(p.y ^ q.y, m_inv(p.x ^ q.x));
         r.x = m_mul(lam, lam) ^ lam ^ p.x ^ q.x ^ CA;
         r.y = m_mul(lam, p.x ^ r.x) ^ r.x ^ p.y;
      end
      return r;
   endfunction

   function automatic aff_t aff_scalar(input aff_t p, input int j);
      aff_t r;
      r.inf = 1'b1; r.x = '0; r.y = '0;
      for (int i = 0; i < j; i++) r = aff_add(r, p);
      return r;
   endfunction

   function automatic int aff_order(input aff_t p);
      aff_t r;
      int   j;
      r = p;
      j = 1;
      while (!r.inf && j < 64) begin
         r = aff_add(r, p);
         j++;
      end
      return j;
   endfunction

   function automatic aff_t to_aff(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
      aff_t       r;
      logic [2:0] zi;
      zi = m_inv(z);
      r.inf = (z == 3'b000);
      r.x = m_mul(x, zi);
      r.y = m_mul(y, m_mul(zi, zi));
      return r;
   endfunction

   function automatic logic [8:0] proj(input aff_t p, input logic [2:0] z);
      return {m_mul(p.x, z), m_mul(p.y, m_mul(z, z)), z};
   endfunction

   task automatic model(input logic [2:0] ax, ay, az, bx, by, bz, input int kmax,
                        output bit f, output int kk, output int lat);
      aff_t p, q, r;
      f = 1'b0; kk = 0; lat = 0;
      if (bz == 3'b000) begin
         f = 1'b1;
      end else if (az != 3'b000) begin
         p = to_aff(ax, ay, az);
         q = to_aff(bx, by, bz);
         r = p;
         for (int i = 1; i <= kmax; i++) begin
            kk = i;
            if (r.inf) break;
            if (r.x == q.x && r.y == q.y) begin
               f = 1'b1;
               break;
            end
            if (i == kmax) break;
            r = aff_add(r, p);
         end
         lat = 2 * kk - 1;
      end
   endtask

   // ---------------- stimulus driver ----------------
   task automatic launch(input bit sel, input logic [2:0] ax, ay, az, bx, by, bz, input int glitch,
                         output bit f, output int kk, output int lat, output int bcnt, output bit bdone);
      int e;
      bit fin;
      @(negedge clk);
      px = ax; py = ay; pz = az; qx = bx; qy = by; qz = bz;
      start_a = !sel; start_b = sel;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      e = 0; bcnt = 0; fin = 1'b0;
      while (!fin) begin
         if ((sel ? done_b : done_a) === 1'b1) begin
            fin = 1'b1;
         end else if (e >= 80) begin
            fin = 1'b1;
         end else begin
            if ((sel ? busy_b : busy_a) === 1'b1) bcnt++;
            if (glitch > 0 && e == glitch - 1) begin
               start_a = !sel; start_b = sel;
               px = ax ^ 3'b111; py = ~ay; qx = ~bx; qz = bz ^ 3'b010;
            end else begin
               start_a = 1'b0; start_b = 1'b0;
            end
            @(negedge clk);
            e++;
         end
      end
      start_a = 1'b0; start_b = 1'b0;
      f     = sel ? found_b : found_a;
      kk    = sel ? int'(k_b) : int'(k_a);
      bdone = sel ? busy_b : busy_a;
      lat   = e;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({busy_a, done_a, found_a, k_a} !== 7'b0) begin
         bad++; $display("FAIL reset_a got=%b want=0000000", {busy_a, done_a, found_a, k_a});
      end
      total++;
      if ({busy_b, done_b, found_b, k_b} !== 7'b0) begin
         bad++; $display("FAIL reset_b got=%b want=0000000", {busy_b, done_b, found_b, k_b});
      end
      rst = 1'b0;
   endtask

   task automatic test_self_match();
      bit f, bd;
      int kk, lat, bc;
      launch(1'b0, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b001, 0, f, kk, lat, bc, bd);
      total++; if (f !== 1'b1) begin bad++; $display("FAIL self_found got=%0d want=1", f); end
      total++; if (kk !== 1) begin bad++; $display("FAIL self_k got=%0d want=1", kk); end
      total++; if (lat !== 1) begin bad++; $display("FAIL self_latency got=%0d want=1", lat); end
      total++; if (bc !== 1) begin bad++; $display("FAIL self_busy_cycles got=%0d want=1", bc); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL self_busy_at_done got=%0d want=0", bd); end
      @(negedge clk);
      total++;
      if ({done_a, found_a, k_a} !== 6'b0_1_0001) begin
         bad++; $display("FAIL self_hold got=%b want=010001", {done_a, found_a, k_a});
      end
   endtask

   task automatic test_golden();
      bit         f, bd;
      int         kk, lat, bc, ord;
      logic [8:0] qv;
      ord = aff_order(gp);
      for (int j = 1; j < ord; j++) begin
         qv = proj(aff_scalar(gp, j), 3'b001);
         launch(1'b0, 3'b110, 3'b001, 3'b001, qv[8:6], qv[5:3], qv[2:0], 0, f, kk, lat, bc, bd);
         total++; if (f !== 1'b1) begin bad++; $display("FAIL golden_found j=%0d got=%0d want=1", j, f); end
         total++; if (kk !== j) begin bad++; $display("FAIL golden_k j=%0d got=%0d want=%0d", j, kk, j); end
         total++;
         if (lat !== 2 * j - 1) begin
            bad++; $display("FAIL golden_latency j=%0d got=%0d want=%0d", j, lat, 2 * j - 1);
         end
         @(negedge clk);
         total++; if (done_a !== 1'b0) begin bad++; $display("FAIL golden_done_pulse j=%0d got=1 want=0", j); end
      end
   endtask

   task automatic test_no_multiple();
      bit f, bd;
      int kk, lat, bc, ord;
      ord = aff_order(gp);
      launch(1'b0, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 0, f, kk, lat, bc, bd);
      total++; if (f !== 1'b0) begin bad++; $display("FAIL order_found got=%0d want=0", f); end
      total++; if (kk !== ord) begin bad++; $display("FAIL order_k got=%0d want=%0d", kk, ord); end
      total++; if (lat !== 2 * ord - 1) begin bad++; $display("FAIL order_latency got=%0d want=%0d", lat, 2 * ord - 1); end
      launch(1'b1, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 0, f, kk, lat, bc, bd);
      total++; if (f !== 1'b0) begin bad++; $display("FAIL kmax_found got=%0d want=0", f); end
      total++; if (kk !== 3) begin bad++; $display("FAIL kmax_k got=%0d want=3", kk); end
      total++; if (lat !== 5) begin bad++; $display("FAIL kmax_latency got=%0d want=5", lat); end
   endtask

   task automatic test_infinity();
      bit f, bd;
      int kk, lat, bc;
      launch(1'b0, 3'b101, 3'b011, 3'b100, 3'b010, 3'b111, 3'b000, 0, f, kk, lat, bc, bd);
      total++; if (f !== 1'b1) begin bad++; $display("FAIL qinf_found got=%0d want=1", f); end
      total++; if (kk !== 0) begin bad++; $display("FAIL qinf_k got=%0d want=0", kk); end
      total++; if (lat !== 0) begin bad++; $display("FAIL qinf_latency got=%0d want=0", lat); end
      total++; if (bc !== 0) begin bad++; $display("FAIL qinf_busy_cycles got=%0d want=0", bc); end
      launch(1'b0, 3'b101, 3'b011, 3'b000, 3'b110, 3'b001, 3'b001, 0, f, kk, lat, bc, bd);
      total++; if (f !== 1'b0) begin bad++; $display("FAIL pinf_found got=%0d want=0", f); end
      total++; if (kk !== 0) begin bad++; $display("FAIL pinf_k got=%0d want=0", kk); end
      total++; if (lat !== 0) begin bad++; $display("FAIL pinf_latency got=%0d want=0", lat); end
   endtask

   task automatic test_ignored_start();
      bit f, bd;
      int kk, lat, bc, ord;
      ord = aff_order(gp);
      launch(1'b0, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 2, f, kk, lat, bc, bd);
      total++; if (f !== 1'b0) begin bad++; $display("FAIL restart_found got=%0d want=0", f); end
      total++; if (kk !== ord) begin bad++; $display("FAIL restart_k got=%0d want=%0d", kk, ord); end
      total++; if (lat !== 2 * ord - 1) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", lat, 2 * ord - 1); end
   endtask

   task automatic test_back_to_back();
      bit         f, bd;
      int         kk, lat, bc;
      logic [8:0] qv;
      qv = proj(aff_scalar(gp, 2), 3'b001);
      launch(1'b0, 3'b110, 3'b001, 3'b001, qv[8:6], qv[5:3], qv[2:0], 0, f, kk, lat, bc, bd);
      total++; if ({f, kk[3:0], lat[3:0]} !== {1'b1, 4'd2, 4'd3}) begin
         bad++; $display("FAIL b2b_first got=%0d/%0d/%0d want=1/2/3", f, kk, lat);
      end
      qv = proj(aff_scalar(gp, 3), 3'b101);
      launch(1'b0, 3'b110, 3'b001, 3'b001, qv[8:6], qv[5:3], qv[2:0], 0, f, kk, lat, bc, bd);
      total++; if ({f, kk[3:0], lat[3:0]} !== {1'b1, 4'd3, 4'd5}) begin
         bad++; $display("FAIL b2b_second got=%0d/%0d/%0d want=1/3/5", f, kk, lat);
      end
   endtask

   task automatic test_reset_mid();
      bit f, bd, seen;
      int kk, lat, bc;
      @(negedge clk);
      px = 3'b110; py = 3'b001; pz = 3'b001; qx = 3'b000; qy = 3'b000; qz = 3'b001;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({busy_a, done_a, found_a, k_a} !== 7'b0) begin
         bad++; $display("FAIL midreset_outputs got=%b want=0000000", {busy_a, done_a, found_a, k_a});
      end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen = seen | done_a; end
      rst = 1'b0;
      repeat (30) begin @(negedge clk); seen = seen | done_a | busy_a; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=1 want=0"); end
      launch(1'b0, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b001, 0, f, kk, lat, bc, bd);
      total++; if ({f, kk[3:0], lat[3:0]} !== {1'b1, 4'd1, 4'd1}) begin
         bad++; $display("FAIL midreset_restart got=%0d/%0d/%0d want=1/1/1", f, kk, lat);
      end
   endtask

   task automatic test_random();
      aff_t       p, q;
      logic [2:0] ax, ay, az, bx, by, bz, zq;
      logic [8:0] v;
      int         idx, mode, ek, el, kk, lat, bc;
      bit         sel, ef, f, bd;
      for (int it = 0; it < 40; it++) begin
         idx = $urandom_range(0, cpx.size() - 1);
         p.inf = 1'b0; p.x = cpx[idx]; p.y = cpy[idx];
         v = proj(p, 3'($urandom_range(1, 7)));
         {ax, ay, az} = v;
         mode = $urandom_range(0, 3);
         if (mode <= 1) begin
            q = aff_scalar(p, $urandom_range(1, 16));
         end else if (mode == 2) begin
            idx = $urandom_range(0, cpx.size() - 1);
            q.inf = 1'b0; q.x = cpx[idx]; q.y = cpy[idx];
         end else begin
            q.inf = 1'b0; q.x = 3'($urandom_range(0, 7)); q.y = 3'($urandom_range(0, 7));
         end
         zq = 3'($urandom_range(1, 7));
         if (q.inf) {bx, by, bz} = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'b000};
         else {bx, by, bz} = proj(q, zq);
         if ($urandom_range(0, 9) == 0) az = 3'b000;
         sel = ($urandom_range(0, 3) == 0);
         model(ax, ay, az, bx, by, bz, sel ? 3 : 14, ef, ek, el);
         launch(sel, ax, ay, az, bx, by, bz, 0, f, kk, lat, bc, bd);
         total++; if (f !== ef) begin bad++; $display("FAIL rand_found it=%0d got=%0d want=%0d", it, f, ef); end
         total++; if (kk !== ek) begin bad++; $display("FAIL rand_k it=%0d got=%0d want=%0d", it, kk, ek); end
         total++; if (lat !== el) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, lat, el); end
         total++; if (bc !== el) begin bad++; $display("FAIL rand_busy_cycles it=%0d got=%0d want=%0d", it, bc, el); end
      end
   endtask

   initial begin
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            if ((m_mul(3'(y), 3'(y)) ^ m_mul(3'(x), 3'(y))) ==
                (m_mul(m_mul(3'(x), 3'(x)), 3'(x)) ^ m_mul(CA, m_mul(3'(x), 3'(x))) ^ CB)) begin
               cpx.push_back(3'(x));
               cpy.push_back(3'(y));
            end
         end
      end
      gp.inf = 1'b0; gp.x = 3'b110; gp.y = 3'b001;
      test_reset();
      test_self_match();
      test_golden();
      test_no_multiple();
      test_infinity();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ld_point_log_search.md
# ld_point_log_search

Sequential discrete-log search engine for López-Dahab projective points over GF(2^3); it is the inverse direction of the point generator. Given base point P and target Q, it walks P, 2P, 3P, … one multiple per two clocks, using the existing `PointDouble` and `pointAddition` combinational cores. It reports the smallest k with kP = Q, or reports the order of P / exhaustion when no match exists. It sits beside the point generator and is used to cross-check generated sequences and key material.

## Interface
- `N`, 3, field width in bits (GF(2^N), fixed to 3 by the field package)
- `K_MAX`, 14, last multiple tested before giving up
- `KW`, 4, width of the scalar counter; must satisfy 2^KW > K_MAX
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request pulse; sampled only in IDLE
- `px`, `py`, `pz`  in  N each  base point P (LD projective)
- `qx`, `qy`, `qz`  in  N each  target point Q (LD projective)
- `busy`  out  1  high from the start edge until `done`
- `done`  out  1  one-cycle pulse, result valid
- `found`  out  1  Q = kP found; valid with `done`, held until next start
- `k`  out  KW  result scalar; valid with `done`, held until next start

## Operation
- Field: GF(2^3), reduction polynomial x^3+x+1. Addition is XOR; multiplication is carry-less multiplication followed by reduction. Point at infinity is any point with Z = 0.
- LD equality of R and Q, both with Z ≠ 0, is the conjunction of two checks:
  - X_R·Z_Q = X_Q·Z_R
  - Y_R·Z_Q² = Y_Q·Z_R²
- FSM states: IDLE, CMP, STEP, DONE.
- IDLE:
  - On `start`, latch P and Q, set `busy` = 1, clear `found`.
  - If qz = 0: go to DONE with found = 1, k = 0.
  - Else if pz = 0: go to DONE with found = 0, k = 0.
  - Otherwise set R ← P, k ← 1, and go to CMP.
- CMP (priority order):
  1. R.Z = 0: go to DONE, found = 0, k holds the order of P.
  2. R equals Q: go to DONE, found = 1.
  3. k = K_MAX: go to DONE, found = 0.
  4. Otherwise go to STEP.
- STEP:
  - If k = 1, R ← PointDouble(P). Otherwise R ← pointAddition(R, P).
  - k ← k+1, then return to CMP.
  - `pointAddition` is never fed R = P, so no doubling special case is needed.
- DONE: `done` = 1 for exactly one cycle, `busy` ← 0, then IDLE.
- `start` while not in IDLE is ignored; there is no queueing.
- Latched P and Q are used throughout the search, so input changes mid-search have no effect.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `found` = 0, `k` = 0, R and latched P/Q = 0.
- Reset asserted mid-search aborts immediately to the reset values. No `done` is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Edge 0 is the edge that samples `start`. `busy` is visible after edge 0.
- Latency to `done` visible:
  - Q or P at infinity: after edge 0, the same edge as the start sample.
  - Resolution at multiple k (match, infinity, or K_MAX): after edge 2k−1.
- Worst case is 2·K_MAX−1 edges, which is 27 with the defaults.
- `start` may be asserted in the cycle right after `done`, because the FSM is back in IDLE then.
- Critical path is the CMP cycle: one point-add output is registered first, then the compare needs 4 multiplies plus 2 squares in parallel.

## Structure
- Package `ld_gf8_pkg` holds:
  - `N`
  - the reduction polynomial constant `GF_POLY` = 3'b011
  - functions `gf_mul` and `gf_sq`
  - typedef `ld_point_t` (x, y, z fields)
  - the FSM state enum
- Sub-module `ld_point_eq`: combinational; inputs are two `ld_point_t` values; output `eq` implements the LD equality above.
- Top level instantiates one `PointDouble`, one `pointAddition`, and one `ld_point_eq`, plus the FSM and the k counter.

## Test plan
- P = Q = (110,001,001), start → `done` after edge 1, found = 1, k = 1, and `busy` was high for 1 cycle.
- Golden vectors: P = (110,001,001) and Q = P(j) from the point-generator dump, for each j up to the first Z = 000 entry → found = 1, k = j, `done` after edge 2j−1.
- P = (110,001,001), Q = (000,000,001), which is not a multiple → found = 0, k = order of P (index of the first Z = 000 in the dump), `done` after edge 2k−1. Force an order > K_MAX via K_MAX = 3 → found = 0, k = 3, `done` after edge 5.
- Infinity inputs:
  - qz = 000 → found = 1, k = 0, `done` after edge 0.
  - pz = 000 with qz ≠ 0 → found = 0, k = 0.
- Second `start` pulse at edge 2 of a running search → ignored; result unchanged. A back-to-back `start` the cycle after `done` → accepted.
- Assert `rst` at edge 3 mid-search → all outputs 0 immediately and no `done`. A fresh `start` then completes normally.
